switch_input_conditioner: RTL and testbench

//   Front-end stage between the raw board switches and the generated gate-level circuit (e.g. NOR set/reset latches).

---
 rtl/vcd_io_pkg.sv | 11 +
 rtl/debounce_channel.sv | 80 ++++++++
 rtl/switch_input_conditioner.sv | 38 +++
 tb/tb_switch_input_conditioner.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/vcd_io_pkg.sv
// Shared types and elaboration helpers for the switch input front-end.
package vcd_io_pkg;

    typedef enum logic {DB_IDLE, DB_QUAL} db_state_t;

    // True when a counter of cntW bits can represent every count up to cycles.
    function automatic bit cntWidthOk(input int cntW, input longint cycles);
        return (cycles >= 1) && ((longint'(1) << cntW) >= cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-FF synchroniser, tick-gated debounce counter and
// registered rise/fall pulses aligned with the clean level change.
module debounce_channel
    import vcd_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tickEn,
    input  logic swRaw,
    output logic swClean,
    output logic swRise,
    output logic swFall
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncS1;
    logic             syncS2;
    db_state_t        state;
    db_state_t        stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [CNT_W-1:0] cntEff;
    logic             cleanNext;
    logic             riseNext;
    logic             fallNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncS1  <= 1'b0;
            syncS2  <= 1'b0;
            state   <= DB_IDLE;
            cnt     <= '0;
            swClean <= 1'b0;
            swRise  <= 1'b0;
            swFall  <= 1'b0;
        end else begin
            syncS1  <= swRaw;
            syncS2  <= syncS1;
            state   <= stateNext;
            cnt     <= cntNext;
            swClean <= cleanNext;
            swRise  <= riseNext;
            swFall  <= fallNext;
        end
    end

    // IDLE always counts from zero, so a one-cycle debounce accepts on the
    // very edge the difference is first seen.
    assign cntEff = (state == DB_IDLE) ? '0 : cnt;

    always_comb begin
        stateNext = state;
        cntNext   = cntEff;
        cleanNext = swClean;
        riseNext  = 1'b0;
        fallNext  = 1'b0;
        if (syncS2 == swClean) begin
            stateNext = DB_IDLE;
            cntNext   = '0;
        end else if (tickEn) begin
            if (cntEff == LAST_CNT) begin
                stateNext = DB_IDLE;
                cntNext   = '0;
                cleanNext = syncS2;
                riseNext  = syncS2;
                fallNext  = ~syncS2;
            end else begin
                stateNext = DB_QUAL;
                cntNext   = cntEff + CNT_W'(1);
            end
        end else begin
            stateNext = DB_QUAL;
        end
    end

endmodule

// File: rtl/switch_input_conditioner.sv
// Synchronises and debounces N_CH raw switches into clean levels plus
// single-cycle rise/fall pulses for the downstream latch logic.
module switch_input_conditioner
    import vcd_io_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick_en,
    input  logic [N_CH-1:0] sw_raw,
    output logic [N_CH-1:0] sw_clean,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall
);

    if (!cntWidthOk(CNT_W, longint'(DEBOUNCE_CYCLES))) begin : gBadCntW
        $error("CNT_W too small for DEBOUNCE_CYCLES");
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : gCh
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) uChannel (
            .clk    (clk),
            .rst_n  (rst_n),
            .tickEn (tick_en),
            .swRaw  (sw_raw[gi]),
            .swClean(sw_clean[gi]),
            .swRise (sw_rise[gi]),
            .swFall (sw_fall[gi])
        );
    end

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Directed bench: a per-cycle vector table plus hand-written reset sequences.
module tb_switch_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_en = 1'b1;
    logic [1:0] sw_raw = 2'b00;
    logic [1:0] sw_clean;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [1:0] raw;
        logic       tick;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    vec_t vecs[$];

    switch_input_conditioner #(
        .N_CH           (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_en (tick_en),
        .sw_raw  (sw_raw),
        .sw_clean(sw_clean),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [1:0] act, input logic [1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] c, input logic [1:0] r, input logic [1:0] f);
        checkVal({tag, ".clean"}, sw_clean, c);
        checkVal({tag, ".rise"}, sw_rise, r);
        checkVal({tag, ".fall"}, sw_fall, f);
        $display("%s raw=%b tick=%b clean=%b rise=%b fall=%b", tag, sw_raw, tick_en, sw_clean, sw_rise, sw_fall);
    endtask

    task automatic step(input logic [1:0] raw, input logic tick);
        sw_raw  = raw;
        tick_en = tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [1:0] raw, input logic tick, input logic [1:0] c,
                       input logic [1:0] r, input logic [1:0] f);
        vec_t v;
        v.raw = raw; v.tick = tick; v.clean = c; v.rise = r; v.fall = f;
        vecs.push_back(v);
    endtask

    // Raw change with tick_en held high: old level for 5 edges, new level with
    // pulse on the 6th edge, then one quiet cycle.
    task automatic addSettle(input logic [1:0] raw, input logic [1:0] oldC, input logic [1:0] newC,
                             input logic [1:0] r, input logic [1:0] f);
        for (int k = 0; k < 5; k++) add(raw, 1'b1, oldC, 2'b00, 2'b00);
        add(raw, 1'b1, newC, r, f);
        add(raw, 1'b1, newC, 2'b00, 2'b00);
    endtask

    initial begin
        // Back to idle from 11, then clean step on channel 0 and its release.
        addSettle(2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        addSettle(2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
        addSettle(2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
        // Bounce on channel 0: never holds long enough.
        begin
            logic [1:0] bounce [14];
            bounce = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00,
                       2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
            for (int k = 0; k < 14; k++) add(bounce[k], 1'b1, 2'b00, 2'b00, 2'b00);
        end
        // Tick gating on channel 1: ticks at E0,E3,...; accepts on 4th tick in QUAL (E12).
        for (int k = 0; k < 12; k++) add(2'b10, (k % 3) == 0, 2'b00, 2'b00, 2'b00);
        add(2'b10, 1'b1, 2'b10, 2'b10, 2'b00);
        add(2'b10, 1'b0, 2'b10, 2'b00, 2'b00);
        // Simultaneous channels.
        addSettle(2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
        addSettle(2'b11, 2'b00, 2'b11, 2'b11, 2'b00);
        addSettle(2'b10, 2'b11, 2'b10, 2'b00, 2'b01);

        // Reset with switches held high.
        sw_raw  = 2'b11;
        tick_en = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset", 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(2'b11, 1'b1);
            checkAll($sformatf("rel_e%0d", k), 2'b00, 2'b00, 2'b00);
        end
        step(2'b11, 1'b1);
        checkAll("rel_e5", 2'b11, 2'b11, 2'b00);
        step(2'b11, 1'b1);
        checkAll("rel_e6", 2'b11, 2'b00, 2'b00);

        foreach (vecs[i]) begin
            step(vecs[i].raw, vecs[i].tick);
            checkAll($sformatf("vec%0d", i), vecs[i].clean, vecs[i].rise, vecs[i].fall);
        end

        // Mid-count reset: clean=10, raise channel 0, reset when its count is 2.
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 1'b1);
            checkAll($sformatf("mid_e%0d", k), 2'b10, 2'b00, 2'b00);
        end
        rst_n = 1'b0;
        #1;
        checkAll("mid_rst", 2'b00, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(2'b11, 1'b1);
            checkAll($sformatf("post_e%0d", k), 2'b00, 2'b00, 2'b00);
        end
        step(2'b11, 1'b1);
        checkAll("post_e5", 2'b11, 2'b11, 2'b00);
        step(2'b11, 1'b1);
        checkAll("post_e6", 2'b11, 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
